efpga_fabric_top: RTL and testbench
===================================

Name: efpga_fabric_top

Overview:
- Small self-contained eFPGA: 28 configurable logic/I/O cells, one per pad, plus two 56-bit user config vectors.
- Configuration arrives as a 32-bit word stream from any of three front-ends: parallel self-write, UART, or bit-bang serial.
- Once configured, the fabric implements a user design on the pads. Reference user design: a 28-bit counter with synchronous reset on O_top[0].
- Sits at the chip top, between the pad ring and the configuration sources.

Parameters:
- NUM_CELLS, 28, number of pad cells (I_top/T_top/O_top width).
- UART_DIV, 868, CLK cycles per UART bit (8N1).
- SYNC_WORD, 32'hFAB0_FAB1, word that starts a configuration frame.

Ports:
- CLK  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- O_top  in  28  pad inputs into the fabric.
- I_top  out  28  pad outputs from the fabric.
- T_top  out  28  pad output enables (1 = drive).
- A_config_C  out  56  user config vector A.
- B_config_C  out  56  user config vector B.
- SelfWriteData  in  32  parallel config word.
- SelfWriteStrobe  in  1  one-cycle strobe; accepts SelfWriteData.
- Rx  in  1  UART receive line, idle high.
- s_clk  in  1  bit-bang serial clock (asynchronous; synchronised internally).
- s_data  in  1  bit-bang serial data.
- ComActive  out  1  high while a frame is being loaded.
- ReceiveLED  out  1  toggles on every UART byte received.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All config bits, cell flops, A/B vectors, front-end state: 0.
  - I_top=0, T_top=0, ComActive=0, ReceiveLED=0.
- Word sources, merged into one stream:
  - Self-write: a word is taken on any cycle SelfWriteStrobe=1.
  - UART: 8N1, LSB-first bytes, start bit sampled mid-bit. Four bytes form a word, first byte = bits[31:24].
  - Serial: s_clk and s_data pass through a 2-flop synchroniser. On each s_clk rising edge, s_data shifts into the LSB; every 32 bits form a word.
  - Simultaneous words from different sources: priority self-write > UART > serial; the losing word is dropped.
- Loader FSM:
  - IDLE: SYNC_WORD moves to LOAD with count=0, ComActive=1. Other words are ignored.
  - LOAD: each word is written to config word[count], count increments. After word 59, return to IDLE and set ComActive=0.
  - A SYNC_WORD arriving during LOAD restarts count at 0.
- Config map (60 words):
  - Words 2k/2k+1 (k=0..27) form cell k's 64-bit config.
  - Words 56,57 = A_config_C {w57[23:0], w56}.
  - Words 58,59 = B_config_C {w59[23:0], w58}.
  - Config changes take effect the cycle after each word is written.
- Cell config, 64-bit, LSB first:
  - [15:0] LUT4 truth table.
  - [21:16] sel0, [27:22] sel1, [33:28] sel2, [39:34] sel3.
  - [40] ff_en, [41] carry_en, [42] oe. Remaining bits unused.
- Source select (6-bit):
  - 0-27 = O_top[n].
  - 32-59 = Q of cell n-32, registered value only, so no combinational loops.
  - 28-31 and 60-63 = constant 1.
- Cell datapath:
  - LUT index = {I3,I2,I1,I0}.
  - If carry_en, I3 is replaced by cin.
  - cin of cell 0 = 1; cin(k+1) = cout(k) = cin(k) & I0.
  - Q is updated every CLK with the LUT output.
  - I_top[k] = ff_en ? Q : LUT output. T_top[k] = oe.
- Unconfigured fabric (all zero): I_top=0, T_top=0.

Decomposition:
- Package efpga_pkg: SYNC_WORD, config word count (60), cell config field offsets, source-select encodings.
- One natural sub-module: efpga_cell (LUT4, input muxes, carry, flop), instantiated 28 times.
- Front-ends and the loader live in the top.

Test Plan:
- Reset then idle -> I_top=0, T_top=0, A/B=0, ComActive=0.
- Self-write SYNC_WORD + 60 words of a counter config, then O_top=1 for 5 cycles, then 0:
  - Counter config per cell k: I0=Q_k, I1=O_top[0], carry_en, LUT=~I1&(I0^I3), ff_en, oe=1.
  - Response: T_top=0x FFFFFFF; I_top=0 during reset, then increments 1,2,3... each cycle, matching the reference counter for 100 cycles.
- Same frame over UART at UART_DIV -> identical I_top/T_top. ReceiveLED toggles 244 times (61 words × 4 bytes); ComActive high only during load.
- Same frame via s_clk/s_data -> identical behaviour.
- Words 56-59 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> A_config_C=0x22222211111111, B_config_C=0x44444433333333.
- resetn low mid-load, then a full reload -> everything cleared on reset; the reload configures correctly; a SYNC_WORD mid-frame restarts the count.

Source files
------------

// File: rtl/efpga_pkg.sv
// Shared constants, config field layout and FSM encodings for the eFPGA fabric.
package efpga_pkg;

  localparam int          NUM_CELLS = 28;
  localparam int          CFG_WORDS = 60;
  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  // Per-cell 64-bit config layout
  localparam int SEL0_LSB     = 16;
  localparam int SEL1_LSB     = 22;
  localparam int SEL2_LSB     = 28;
  localparam int SEL3_LSB     = 34;
  localparam int FF_EN_BIT    = 40;
  localparam int CARRY_EN_BIT = 41;
  localparam int OE_BIT       = 42;

  localparam logic [5:0] SEL_PAD_LAST = 6'd27;
  localparam logic [5:0] SEL_Q_FIRST  = 6'd32;
  localparam logic [5:0] SEL_Q_LAST   = 6'd59;

  typedef enum logic {LD_IDLE, LD_LOAD} ld_state_e;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  // Unassigned encodings read as constant 1.
  function automatic logic src_sel(input logic [5:0] sel,
                                   input logic [NUM_CELLS-1:0] pads,
                                   input logic [NUM_CELLS-1:0] q);
    logic r;
    r = 1'b1;
    if (sel <= SEL_PAD_LAST) begin
      r = pads[sel[4:0]];
    end else if (sel >= SEL_Q_FIRST && sel <= SEL_Q_LAST) begin
      r = q[5'(sel - SEL_Q_FIRST)];
    end
    return r;
  endfunction

endpackage

// File: rtl/efpga_cell.sv
// One logic/I/O cell: four input muxes, LUT4 with optional carry on I3, output flop.
module efpga_cell
  import efpga_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [63:0]          cfg_i,
  input  logic [NUM_CELLS-1:0] pads_i,
  input  logic [NUM_CELLS-1:0] q_all_i,
  input  logic                 cin_i,
  output logic                 i0_o,
  output logic                 q_o,
  output logic                 i_o,
  output logic                 t_o
);

  logic       i1;
  logic       i2;
  logic       i3;
  logic [3:0] lut_idx;
  logic       lut_out;
  logic       q_q;
  logic       unused_cfg;

  assign i0_o = src_sel(cfg_i[SEL0_LSB +: 6], pads_i, q_all_i);
  assign i1   = src_sel(cfg_i[SEL1_LSB +: 6], pads_i, q_all_i);
  assign i2   = src_sel(cfg_i[SEL2_LSB +: 6], pads_i, q_all_i);
  assign i3   = cfg_i[CARRY_EN_BIT] ? cin_i : src_sel(cfg_i[SEL3_LSB +: 6], pads_i, q_all_i);

  assign lut_idx = {i3, i2, i1, i0_o};
  assign lut_out = cfg_i[lut_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= 1'b0;
    else         q_q <= lut_out;
  end

  assign q_o        = q_q;
  assign i_o        = cfg_i[FF_EN_BIT] ? q_q : lut_out;
  assign t_o        = cfg_i[OE_BIT];
  assign unused_cfg = ^cfg_i[63:43];

endmodule

// File: rtl/efpga_fabric_top.sv
// eFPGA top: three config front-ends merged into one word stream, frame loader, 28 cells.
module efpga_fabric_top
  import efpga_pkg::*;
#(
  parameter int UART_DIV = 868
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic [NUM_CELLS-1:0] O_top,
  output logic [NUM_CELLS-1:0] I_top,
  output logic [NUM_CELLS-1:0] T_top,
  output logic [55:0]          A_config_C,
  output logic [55:0]          B_config_C,
  input  logic [31:0]          SelfWriteData,
  input  logic                 SelfWriteStrobe,
  input  logic                 Rx,
  input  logic                 s_clk,
  input  logic                 s_data,
  output logic                 ComActive,
  output logic                 ReceiveLED
);

  localparam logic [15:0] DIV_M1    = 16'(UART_DIV - 1);
  localparam logic [15:0] HALF_M1   = 16'(UART_DIV / 2 - 1);
  localparam logic [5:0]  LAST_WORD = 6'(CFG_WORDS - 1);

  // Word handshake: each source raises its *_wvld for exactly one cycle with the
  // word alongside; there is no ready, so a word losing arbitration is dropped.
  logic        uart_wvld, ser_wvld, word_vld;
  logic [31:0] uart_word, ser_word, word;

  // UART receiver
  uart_state_e u_state_q, u_state_d;
  logic [1:0]  rx_sync_q;
  logic [15:0] u_cnt_q, u_cnt_d;
  logic [2:0]  u_bit_q, u_bit_d;
  logic [7:0]  u_sh_q, u_sh_d;
  logic [1:0]  ub_cnt_q;
  logic [23:0] uw_q;
  logic        led_q;
  logic        byte_done;
  logic        rx_s;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    u_state_d = u_state_q;
    u_cnt_d   = u_cnt_q;
    u_bit_d   = u_bit_q;
    u_sh_d    = u_sh_q;
    byte_done = 1'b0;
    case (u_state_q)
      U_IDLE: if (!rx_s) begin
        u_state_d = U_START;
        u_cnt_d   = '0;
      end
      U_START: if (u_cnt_q == HALF_M1) begin
        u_cnt_d   = '0;
        u_bit_d   = '0;
        u_state_d = rx_s ? U_IDLE : U_DATA;
      end else u_cnt_d = u_cnt_q + 16'd1;
      U_DATA: if (u_cnt_q == DIV_M1) begin
        u_cnt_d = '0;
        u_sh_d  = {rx_s, u_sh_q[7:1]};
        if (u_bit_q == 3'd7) u_state_d = U_STOP;
        else                 u_bit_d   = u_bit_q + 3'd1;
      end else u_cnt_d = u_cnt_q + 16'd1;
      U_STOP: if (u_cnt_q == DIV_M1) begin
        u_cnt_d   = '0;
        u_state_d = U_IDLE;
        byte_done = rx_s;
      end else u_cnt_d = u_cnt_q + 16'd1;
      default: u_state_d = U_IDLE;
    endcase
  end

  assign uart_wvld = byte_done && (ub_cnt_q == 2'd3);
  assign uart_word = {uw_q, u_sh_q};

  // Bit-bang serial: the extra stage on s_clk gives the rising-edge detect.
  logic [2:0]  sclk_q;
  logic [1:0]  sdat_q;
  logic [30:0] ser_sh_q;
  logic [4:0]  ser_bits_q;
  logic        ser_rise;

  assign ser_rise  = sclk_q[1] & ~sclk_q[2];
  assign ser_wvld  = ser_rise && (ser_bits_q == 5'd31);
  assign ser_word  = {ser_sh_q, sdat_q[1]};

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      u_state_q  <= U_IDLE;
      rx_sync_q  <= '0;
      u_cnt_q    <= '0;
      u_bit_q    <= '0;
      u_sh_q     <= '0;
      ub_cnt_q   <= '0;
      uw_q       <= '0;
      led_q      <= 1'b0;
      sclk_q     <= '0;
      sdat_q     <= '0;
      ser_sh_q   <= '0;
      ser_bits_q <= '0;
    end else begin
      u_state_q <= u_state_d;
      rx_sync_q <= {rx_sync_q[0], Rx};
      u_cnt_q   <= u_cnt_d;
      u_bit_q   <= u_bit_d;
      u_sh_q    <= u_sh_d;
      if (byte_done) begin
        ub_cnt_q <= ub_cnt_q + 2'd1;
        uw_q     <= {uw_q[15:0], u_sh_q};
        led_q    <= ~led_q;
      end
      sclk_q <= {sclk_q[1:0], s_clk};
      sdat_q <= {sdat_q[0], s_data};
      if (ser_rise) begin
        ser_sh_q   <= {ser_sh_q[29:0], sdat_q[1]};
        ser_bits_q <= ser_bits_q + 5'd1;
      end
    end
  end

  assign word_vld = SelfWriteStrobe | uart_wvld | ser_wvld;
  assign word     = SelfWriteStrobe ? SelfWriteData : (uart_wvld ? uart_word : ser_word);

  // Loader: a sync word always (re)starts a frame, even mid-load.
  ld_state_e   ld_state_q, ld_state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        cfg_we;
  logic [31:0] cfg_q [CFG_WORDS];

  always_comb begin
    ld_state_d = ld_state_q;
    cnt_d      = cnt_q;
    cfg_we     = 1'b0;
    if (word_vld) begin
      if (word == SYNC_WORD) begin
        ld_state_d = LD_LOAD;
        cnt_d      = '0;
      end else if (ld_state_q == LD_LOAD) begin
        cfg_we = 1'b1;
        if (cnt_q == LAST_WORD) begin
          ld_state_d = LD_IDLE;
          cnt_d      = '0;
        end else cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ld_state_q <= LD_IDLE;
      cnt_q      <= '0;
      for (int w = 0; w < CFG_WORDS; w++) cfg_q[w] <= '0;
    end else begin
      ld_state_q <= ld_state_d;
      cnt_q      <= cnt_d;
      for (int w = 0; w < CFG_WORDS; w++) begin
        if (cfg_we && cnt_q == 6'(w)) cfg_q[w] <= word;
      end
    end
  end

  assign ComActive  = (ld_state_q == LD_LOAD);
  assign ReceiveLED = led_q;
  assign A_config_C = {cfg_q[57][23:0], cfg_q[56]};
  assign B_config_C = {cfg_q[59][23:0], cfg_q[58]};

  logic unused_ab;
  assign unused_ab = ^{cfg_q[57][31:24], cfg_q[59][31:24]};

  // Carry ripples on I0 only, which never depends on the carry itself.
  logic [NUM_CELLS-1:0] q_all;
  logic [NUM_CELLS-1:0] i0_all;
  logic [NUM_CELLS:0]   carry;

  always_comb begin
    carry[0] = 1'b1;
    for (int k = 0; k < NUM_CELLS; k++) carry[k+1] = carry[k] & i0_all[k];
  end

  for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
    efpga_cell u_cell (
      .clk_i   (CLK),
      .rst_ni  (resetn),
      .cfg_i   ({cfg_q[2*k+1], cfg_q[2*k]}),
      .pads_i  (O_top),
      .q_all_i (q_all),
      .cin_i   (carry[k]),
      .i0_o    (i0_all[k]),
      .q_o     (q_all[k]),
      .i_o     (I_top[k]),
      .t_o     (T_top[k])
    );
  end

endmodule

// File: tb/tb_efpga_fabric_top.sv
// Directed bench: loads a 28-bit counter design through each config front-end and checks it.
module tb_efpga_fabric_top;

  localparam int          DIV  = 8;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [27:0] O_top = 28'h1;
  logic [27:0] I_top, T_top;
  logic [55:0] A_config_C, B_config_C;
  logic [31:0] SelfWriteData = '0;
  logic        SelfWriteStrobe = 1'b0;
  logic        Rx = 1'b1;
  logic        s_clk = 1'b0;
  logic        s_data = 1'b0;
  logic        ComActive, ReceiveLED;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int led_toggles = 0;
  logic led_prev = 1'b0;
  logic [31:0] frame [60];

  efpga_fabric_top #(.UART_DIV(DIV)) dut (
    .CLK(CLK), .resetn(resetn), .O_top(O_top), .I_top(I_top), .T_top(T_top),
    .A_config_C(A_config_C), .B_config_C(B_config_C),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .Rx(Rx), .s_clk(s_clk), .s_data(s_data),
    .ComActive(ComActive), .ReceiveLED(ReceiveLED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ReceiveLED !== led_prev) led_toggles++;
    led_prev = ReceiveLED;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    chk_cnt++;
    assert (obs === want) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, want);
  endtask

  task automatic uart_byte(input logic [7:0] b);
    Rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      tick(DIV);
    end
    Rx = 1'b1;
    tick(DIV);
  endtask

  task automatic send_word(input int src, input logic [31:0] w);
    if (src == 0) begin
      SelfWriteData   = w;
      SelfWriteStrobe = 1'b1;
      tick(1);
      SelfWriteStrobe = 1'b0;
    end else if (src == 1) begin
      uart_byte(w[31:24]);
      uart_byte(w[23:16]);
      uart_byte(w[15:8]);
      uart_byte(w[7:0]);
    end else begin
      for (int i = 31; i >= 0; i--) begin
        s_data = w[i];
        tick(2);
        s_clk = 1'b1;
        tick(4);
        s_clk = 1'b0;
        tick(2);
      end
      tick(2);
    end
  endtask

  task automatic load_frame(input int src);
    send_word(src, SYNC);
    chk("comactive_load", 64'(ComActive), 64'd1);
    for (int w = 0; w < 60; w++) send_word(src, frame[w]);
    tick(1);
    chk("comactive_done", 64'(ComActive), 64'd0);
    chk("t_top", 64'(T_top), 64'h0FFF_FFFF);
    chk("a_cfg", 64'(A_config_C), 64'h0022_2222_1111_1111);
    chk("b_cfg", 64'(B_config_C), 64'h0044_4444_3333_3333);
  endtask

  task automatic run_counter(input int n);
    O_top = 28'h1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("cnt_hold", 64'(I_top), 64'd0);
    end
    for (int i = 1; i <= n; i++) begin
      O_top = {27'($urandom_range(32'h7FF_FFFF, 0)), 1'b0};
      tick(1);
      chk("cnt_run", 64'(I_top), 64'(i));
    end
    O_top = 28'h1;
    tick(1);
    chk("cnt_sreset", 64'(I_top), 64'd0);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    tick(2);
    chk("rst_t_top", 64'(T_top), 64'd0);
    chk("rst_a_cfg", 64'(A_config_C), 64'd0);
    resetn = 1'b1;
    tick(2);
  endtask

  initial begin
    int led_base;
    logic [3:0] ix;
    logic [15:0] lut;
    // Counter cell: I0=Q_k, I1=O_top[0], I3=carry, LUT=~I1&(I0^I3), ff_en, oe.
    for (int i = 0; i < 16; i++) begin
      ix = 4'(i);
      lut[i] = ~ix[1] & (ix[0] ^ ix[3]);
    end
    for (int k = 0; k < 28; k++) begin
      frame[2*k]   = {4'h0, 6'd0, 6'(32 + k), lut};
      frame[2*k+1] = 32'h0000_0700;
    end
    frame[56] = 32'h1111_1111;
    frame[57] = 32'h2222_2222;
    frame[58] = 32'h3333_3333;
    frame[59] = 32'h4444_4444;

    // Reset state
    tick(2);
    chk("rst_i_top", 64'(I_top), 64'd0);
    chk("rst_t_top", 64'(T_top), 64'd0);
    chk("rst_a_cfg", 64'(A_config_C), 64'd0);
    chk("rst_b_cfg", 64'(B_config_C), 64'd0);
    chk("rst_comactive", 64'(ComActive), 64'd0);
    chk("rst_led", 64'(ReceiveLED), 64'd0);
    resetn = 1'b1;
    tick(3);
    chk("idle_i_top", 64'(I_top), 64'd0);
    chk("idle_t_top", 64'(T_top), 64'd0);
    chk("idle_comactive", 64'(ComActive), 64'd0);

    // Self-write
    load_frame(0);
    run_counter(100);

    // UART
    pulse_reset();
    led_base = led_toggles;
    load_frame(1);
    run_counter(20);
    chk("led_toggles", 64'(led_toggles - led_base), 64'd244);

    // Bit-bang serial
    pulse_reset();
    load_frame(2);
    run_counter(20);

    // Reset mid-load clears everything asynchronously
    pulse_reset();
    send_word(0, SYNC);
    for (int w = 0; w < 30; w++) send_word(0, frame[w]);
    chk("partial_t_top", 64'(T_top), 64'h7FFF);
    chk("partial_comactive", 64'(ComActive), 64'd1);
    #3 resetn = 1'b0;
    #1;
    chk("midrst_t_top", 64'(T_top), 64'd0);
    chk("midrst_comactive", 64'(ComActive), 64'd0);
    chk("midrst_i_top", 64'(I_top), 64'd0);
    tick(2);
    resetn = 1'b1;
    tick(2);

    // Garbage words, then a sync mid-frame restarts the count
    send_word(0, SYNC);
    for (int w = 0; w < 10; w++) send_word(0, 32'hDEAD_BEEF);
    tick(1);
    chk("garbage_t_top", 64'(T_top), 64'h1F);
    load_frame(0);
    run_counter(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
